data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 128, giving the storage size in bytes; it is a power of two and at least 8.
REQ-002 SHALL have parameter LATENCY, default 2, giving the wait cycles between request accept and response; legal range 1 to 15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: the CPU is presenting a request.
REQ-006 SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 means store, 0 means load.
REQ-008 SHALL have port req_addr, input, 64 bits: byte address.
REQ-009 SHALL have port req_wdata, input, 64 bits: store data, right-justified.
REQ-010 SHALL have port req_size, input, 4 bits: transfer size in bytes; legal values are 1, 2, 4 and 8.
REQ-011 SHALL have port resp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-012 SHALL have port resp_rdata, output, 64 bits: load data, zero-extended.
REQ-013 SHALL have port resp_err, output, 1 bit: the completed request was illegal.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-015 SHALL drive req_ready=1 only in IDLE; a request is accepted on a cycle with req_valid && req_ready.
REQ-016 SHALL latch req_write, req_addr, req_wdata and req_size on accept; input changes after accept SHALL have no effect on the transaction.
REQ-017 SHALL move IDLE->WAIT on accept and load a wait counter with LATENCY.
REQ-018 SHALL decrement the wait counter once per WAIT cycle and move WAIT->RESP on the cycle the counter reaches 1.
REQ-019 SHALL assert resp_valid for exactly one cycle, in RESP, then return RESP->IDLE.
REQ-020 SHALL place resp_valid LATENCY+1 cycles after the accept edge; back-to-back accepts are therefore LATENCY+2 cycles apart.
REQ-021 SHALL treat a request as illegal if req_size is not in {1,2,4,8}, or addr mod size != 0, or addr+size > DEPTH_BYTES, with addr+size computed without 64-bit wrap.
REQ-022 SHALL, for an illegal request, assert resp_err=1 with resp_valid, drive resp_rdata=0 and leave memory unmodified.
REQ-023 SHALL store little-endian: byte addr+i SHALL receive req_wdata[8i+7:8i] for i from 0 to size-1, and no other bytes SHALL change.
REQ-024 SHALL commit a legal store on the RESP cycle with resp_rdata=0 and resp_err=0.
REQ-025 SHALL return a legal load as resp_rdata[8i+7:8i] = mem[addr+i] for i below size, with upper bytes 0 and resp_err=0.
REQ-026 SHALL drive resp_rdata=0 and resp_err=0 whenever resp_valid=0.
REQ-027 SHALL make a load after a store to the same address return the stored data, with no stale forwarding path required because requests never overlap.
REQ-028 SHALL ignore req_valid while not in IDLE, with no queuing.

Reset
REQ-029 SHALL, while reset=1 at a clock edge, go to IDLE, clear the wait counter, and make the next-cycle outputs req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0.
REQ-030 SHALL, on reset in WAIT or RESP, abort the transaction: no resp_valid, and a pending store is not committed.
REQ-031 SHALL not clear memory contents on reset; they are retained, and are X after power-up.
REQ-032 SHALL not accept a request in a cycle with reset=1.

Verification
REQ-033 SHALL be covered by this scenario: with LATENCY=2, store size 8 of 0x0123456789ABCDEF at addr 0x10, then load size 8 at 0x10 -> resp_rdata=0x0123456789ABCDEF, resp_err=0, resp_valid 3 cycles after each accept.
REQ-034 SHALL be covered by this scenario: after REQ-033, load size 1 at 0x10 -> 0xEF; load size 2 at 0x12 -> 0x89AB; load size 4 at 0x14 -> 0x01234567.
REQ-035 SHALL be covered by this scenario: store size 1 of 0xFF at 0x11, then load size 8 at 0x10 -> 0x0123456789ABFFEF, proving neighbouring bytes are preserved.
REQ-036 SHALL be covered by this scenario: load size 4 at 0x12 (misaligned), size 3 at 0x0, or size 8 at 0x7C with DEPTH_BYTES=128 -> resp_err=1 and resp_rdata=0; a following load at 0x78 still returns its prior value.
REQ-037 SHALL be covered by this scenario: reset asserted the cycle after accepting a store of 0xAA at 0x20 -> no resp_valid and req_ready=1 after reset; a load at 0x20 returns the old value.
REQ-038 SHALL be covered by this scenario: req_valid held high continuously with changing addresses -> exactly one accept per LATENCY+2 cycles, and each response matches the request latched at its accept.

Source files
------------

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Byte-addressed little-endian data memory that answers one CPU
//               load/store request at a time after a fixed wait.
//               An IDLE -> WAIT -> RESP state machine accepts a request only
//               in IDLE. The accepted fields are captured, and one response
//               pulse is issued LATENCY+1 cycles after the accept cycle.
//               Illegal requests complete with resp_err=1 and leave memory
//               untouched. A request is illegal if its size is not 1/2/4/8,
//               if it is misaligned, or if it runs past the end of storage.
// Ports       : clk        - clock, all state updates on the rising edge
//               reset      - synchronous active-high reset
//               req_valid  - request present          (in)
//               req_ready  - request can be accepted   (out)
//               req_write  - 1 store / 0 load          (in)
//               req_addr   - 64-bit byte address       (in)
//               req_wdata  - store data, right-justified (in)
//               req_size   - transfer size in bytes    (in)
//               resp_valid - one-cycle completion pulse (out)
//               resp_rdata - load data, zero-extended  (out)
//               resp_err   - completed request was illegal (out)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int DEPTH_BYTES = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int         c_AW   = $clog2(DEPTH_BYTES);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        w_accept;

    logic        r_write;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [3:0]  r_size;

    logic [7:0]  r_mem [DEPTH_BYTES];

    logic        w_size_ok;
    logic        w_align_ok;
    logic        w_range_ok;
    logic        w_legal;
    logic [64:0] w_end;
    logic [c_AW-1:0] w_base;
    logic [63:0] w_rdata;

    // ------------------------------------------------------------------------
    // Legality of the captured request
    // ------------------------------------------------------------------------
    // One extra bit on the end address so an address near 2^64 cannot wrap
    // around and look in range.
    assign w_end      = {1'b0, r_addr} + {61'd0, r_size};
    assign w_size_ok  = (r_size == 4'd1) || (r_size == 4'd2) ||
                        (r_size == 4'd4) || (r_size == 4'd8);
    assign w_align_ok = ((r_addr[3:0] & (r_size - 4'd1)) == 4'd0);
    assign w_range_ok = (w_end <= 65'(DEPTH_BYTES));
    assign w_legal    = w_size_ok && w_align_ok && w_range_ok;
    assign w_base     = r_addr[c_AW-1:0];

    // ------------------------------------------------------------------------
    // State machine: next state / counter / handshake
    // ------------------------------------------------------------------------
    assign w_accept = req_valid && req_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        case (r_state)
            c_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_nxt = c_WAIT;
                    w_cnt_nxt   = 4'(LATENCY);
                end
            end
            c_WAIT: begin
                // The WAIT state lasts exactly LATENCY cycles.
                // The cycle that sees a count of 1 is the last one.
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = c_RESP;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            c_RESP: begin
                resp_valid  = 1'b1;
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= 4'd0;
            r_write <= 1'b0;
            r_addr  <= 64'd0;
            r_wdata <= 64'd0;
            r_size  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_size  <= req_size;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage: no reset, contents survive reset
    // ------------------------------------------------------------------------
    // A store commits on its RESP edge. A reset during WAIT or RESP blocks
    // the commit, so an aborted store never lands in memory.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == c_RESP) && r_write && w_legal) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < r_size) begin
                    r_mem[w_base + c_AW'(i)] <= r_wdata[8*i +: 8];
                end
            end
        end
    end

    // Byte lanes at or above the transfer size stay zero.
    always_comb begin
        w_rdata = 64'd0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < r_size) begin
                w_rdata[8*i +: 8] = r_mem[w_base + c_AW'(i)];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Response data / error, forced to zero outside the response pulse
    // ------------------------------------------------------------------------
    always_comb begin
        resp_rdata = 64'd0;
        resp_err   = 1'b0;
        if (r_state == c_RESP) begin
            resp_err = !w_legal;
            if (!r_write && w_legal) begin
                resp_rdata = w_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Scoreboard testbench for data_mem_responder. The driver pushes
//               the expected response and accept cycle of each request into a
//               queue. The monitor pops and compares on every resp_valid
//               pulse, and checks the response latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int c_DEPTH = 128;
    localparam int c_LAT   = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [3:0]  req_size;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;

    data_mem_responder #(
        .DEPTH_BYTES (c_DEPTH),
        .LATENCY     (c_LAT)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t q_exp[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   mon_en  = 0;
    bit   last_held = 0;
    int   last_cyc  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------------
    // Monitor: compare each response against the queue head
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (resp_valid) begin
                    checks++;
                    if (q_exp.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, no request outstanding", cyc);
                    end else begin
                        e = q_exp.pop_front();
                        if (resp_rdata !== e.rdata || resp_err !== e.err) begin
                            errors++;
                            $display("FAIL resp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                                     resp_rdata, resp_err, e.rdata, e.err);
                        end
                        checks++;
                        if (cyc - e.cyc != c_LAT + 1) begin
                            errors++;
                            $display("FAIL resp_latency: got %0d cycles, expected %0d", cyc - e.cyc, c_LAT + 1);
                        end
                    end
                end else begin
                    checks++;
                    if (resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
                        errors++;
                        $display("FAIL idle_outputs: got rdata=%h err=%b, expected 0 and 0", resp_rdata, resp_err);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver: issue one request and record its expected response.
    // When hold=1, req_valid stays high after the accept and the inputs are
    // scrambled while the DUT is busy. This shows that those changes are
    // ignored.
    // ------------------------------------------------------------------------
    task automatic send(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [3:0] size, input logic [63:0] exp_rdata,
                        input bit exp_err, input bit hold);
        int   guard;
        exp_t e;
        guard = 0;
        @(negedge clk);
        while (!req_ready) begin
            guard++;
            if (guard > 40) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout: req_ready=0 for %0d cycles, expected 1", guard);
                return;
            end
            if (req_valid) begin
                req_write = 1'b1;
                req_addr  = {$urandom, $urandom};
                req_wdata = {$urandom, $urandom};
                req_size  = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        if (last_held) begin
            checks++;
            if (cyc - last_cyc != c_LAT + 2) begin
                errors++;
                $display("FAIL accept_spacing: got %0d cycles, expected %0d", cyc - last_cyc, c_LAT + 2);
            end
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        e.rdata   = exp_rdata;
        e.err     = exp_err;
        e.cyc     = cyc;
        q_exp.push_back(e);
        last_cyc  = cyc;
        last_held = hold;
        @(negedge clk);
        if (hold) begin
            req_write = 1'b1;
            req_addr  = {$urandom, $urandom};
            req_wdata = {$urandom, $urandom};
            req_size  = 4'($urandom_range(0, 15));
        end else begin
            req_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q_exp.size() != 0 && guard < 60) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q_exp.size());
            q_exp.delete();
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 64'd0;
        req_wdata = 64'd0;
        req_size  = 4'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset state
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b valid=%b rdata=%h err=%b, expected 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        mon_en = 1'b1;

        // Full-width store and load, then narrower loads
        send(1, 64'h10, 64'h0123456789ABCDEF, 4'd8, 64'd0, 0, 0);
        send(0, 64'h10, 64'd0, 4'd8, 64'h0123456789ABCDEF, 0, 0);
        send(0, 64'h10, 64'd0, 4'd1, 64'h00000000000000EF, 0, 0);
        send(0, 64'h12, 64'd0, 4'd2, 64'h00000000000089AB, 0, 0);
        send(0, 64'h14, 64'd0, 4'd4, 64'h0000000001234567, 0, 0);

        // Byte store must preserve neighbours and ignore upper wdata bits
        send(1, 64'h11, 64'hDEADBEEFCAFE12FF, 4'd1, 64'd0, 0, 0);
        send(0, 64'h10, 64'd0, 4'd8, 64'h0123456789ABFFEF, 0, 0);

        // Illegal requests leave memory untouched
        send(1, 64'h78, 64'h1122334455667788, 4'd8, 64'd0, 0, 0);
        send(0, 64'h12, 64'd0, 4'd4, 64'd0, 1, 0);
        send(0, 64'h00, 64'd0, 4'd3, 64'd0, 1, 0);
        send(0, 64'h7C, 64'd0, 4'd8, 64'd0, 1, 0);
        send(1, 64'h7C, 64'hFFFFFFFFFFFFFFFF, 4'd8, 64'd0, 1, 0);
        send(1, 64'h79, 64'h000000000000FFFF, 4'd2, 64'd0, 1, 0);
        send(0, 64'h00, 64'd0, 4'd0, 64'd0, 1, 0);
        send(1, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFF, 4'd8, 64'd0, 1, 0);
        send(0, 64'h78, 64'd0, 4'd8, 64'h1122334455667788, 0, 0);

        // Highest legal position
        send(1, 64'h7E, 64'h000000000000BEEF, 4'd2, 64'd0, 0, 0);
        send(0, 64'h7E, 64'd0, 4'd2, 64'h000000000000BEEF, 0, 0);
        send(0, 64'h78, 64'd0, 4'd8, 64'hBEEF334455667788, 0, 0);

        // Reset during WAIT aborts a pending store
        send(1, 64'h20, 64'h0F0E0D0C0B0A0908, 4'd8, 64'd0, 0, 0);
        drain();
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 64'h20;
        req_wdata = 64'h00000000000000AA;
        req_size  = 4'd1;
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        reset     = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_reset: got ready=%b valid=%b, expected 1 0", req_ready, resp_valid);
        end
        send(0, 64'h20, 64'd0, 4'd1, 64'h0000000000000008, 0, 0);
        send(0, 64'h20, 64'd0, 4'd8, 64'h0F0E0D0C0B0A0908, 0, 0);
        drain();

        // req_valid held high back-to-back with changing requests
        last_held = 0;
        send(1, 64'h40, 64'h00000000CAFEBABE, 4'd4, 64'd0, 0, 1);
        send(0, 64'h40, 64'd0, 4'd4, 64'h00000000CAFEBABE, 0, 1);
        send(0, 64'h42, 64'd0, 4'd2, 64'h000000000000CAFE, 0, 1);
        send(0, 64'h41, 64'd0, 4'd1, 64'h00000000000000BA, 0, 1);
        send(0, 64'h41, 64'd0, 4'd4, 64'd0, 1, 1);
        send(0, 64'h10, 64'd0, 4'd8, 64'h0123456789ABFFEF, 0, 0);
        last_held = 0;
        drain();

        repeat (8) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
